// File: rtl/mem_arbiter.sv
// Round-robin arbiter and fixed-latency sequencer sharing one single-port memory
// between the CPU port and a loader/DMA device port.
module mem_arbiter #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MEM_LAT   = 1,
    parameter int MEM_WORDS = 256
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic              cpu_err,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              dev_req,
    input  logic              dev_we,
    input  logic [ADDR_W-1:0] dev_addr,
    input  logic [DATA_W-1:0] dev_wdata,
    input  logic              dev_lock,
    output logic              dev_ack,
    output logic              dev_err,
    output logic [DATA_W-1:0] dev_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-3:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    // state  | meaning
    // IDLE   | sample requests, arbitrate, latch command, range check
    // ISSUE  | single mem_en strobe for the latched command
    // WAIT   | count down the read latency, capture mem_rdata at zero
    // DONE   | one-cycle ack/err to the owner, update round-robin pointer
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [ADDR_W-2:0] LP_WORDS  = (ADDR_W-1)'(MEM_WORDS);
    localparam logic [2:0]        LP_LAT_M1 = 3'(MEM_LAT - 1);

    state_t            r_state;
    state_t            w_next;
    logic              r_owner_dev;
    logic              r_we;
    logic              r_err;
    logic              r_last_dev;
    logic [ADDR_W-3:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_cpu_rdata;
    logic [DATA_W-1:0] r_dev_rdata;
    logic [2:0]        r_cnt;

    logic              w_grant;
    logic              w_grant_dev;
    logic              w_sel_we;
    logic [ADDR_W-3:0] w_sel_idx;
    logic [DATA_W-1:0] w_sel_wdata;
    logic              w_out_of_range;
    logic              w_unused;

    // Lock only overrides a tie; an idle device port never blocks the CPU.
    assign w_grant        = cpu_req | dev_req;
    assign w_grant_dev    = dev_req & (~cpu_req | dev_lock | ~r_last_dev);
    assign w_sel_we       = w_grant_dev ? dev_we : cpu_we;
    assign w_sel_idx      = w_grant_dev ? dev_addr[ADDR_W-1:2] : cpu_addr[ADDR_W-1:2];
    assign w_sel_wdata    = w_grant_dev ? dev_wdata : cpu_wdata;
    assign w_out_of_range = {1'b0, w_sel_idx} >= LP_WORDS;
    assign w_unused       = ^{cpu_addr[1:0], dev_addr[1:0]};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_grant) begin
                    w_next = w_out_of_range ? S_DONE : S_ISSUE;
                end
            end
            S_ISSUE: w_next = r_we ? S_DONE : S_WAIT;
            S_WAIT: begin
                if (r_cnt == 3'd0) begin
                    w_next = S_DONE;
                end
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_owner_dev <= 1'b0;
            r_we        <= 1'b0;
            r_err       <= 1'b0;
            r_last_dev  <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_cpu_rdata <= '0;
            r_dev_rdata <= '0;
            r_cnt       <= 3'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_grant) begin
                        r_owner_dev <= w_grant_dev;
                        r_we        <= w_sel_we;
                        r_addr      <= w_sel_idx;
                        r_wdata     <= w_sel_wdata;
                        r_err       <= w_out_of_range;
                        // A rejected read completes with zero data.
                        if (w_out_of_range && !w_sel_we) begin
                            if (w_grant_dev) begin
                                r_dev_rdata <= '0;
                            end else begin
                                r_cpu_rdata <= '0;
                            end
                        end
                    end
                end
                S_ISSUE: r_cnt <= LP_LAT_M1;
                S_WAIT: begin
                    if (r_cnt == 3'd0) begin
                        if (r_owner_dev) begin
                            r_dev_rdata <= mem_rdata;
                        end else begin
                            r_cpu_rdata <= mem_rdata;
                        end
                    end else begin
                        r_cnt <= r_cnt - 3'd1;
                    end
                end
                S_DONE:  r_last_dev <= r_owner_dev;
                default: r_cnt <= 3'd0;
            endcase
        end
    end

    assign mem_en    = (r_state == S_ISSUE);
    assign mem_we    = (r_state == S_ISSUE) & r_we;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign busy      = (r_state != S_IDLE);
    assign cpu_ack   = (r_state == S_DONE) & ~r_owner_dev;
    assign dev_ack   = (r_state == S_DONE) & r_owner_dev;
    assign cpu_err   = cpu_ack & r_err;
    assign dev_err   = dev_ack & r_err;
    assign cpu_rdata = r_cpu_rdata;
    assign dev_rdata = r_dev_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: MEM_LAT=1 instance for single transfers,
// arbitration and lock; MEM_LAT=3 instance for latency and mid-access reset.
module tb_mem_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    // MEM_LAT=1 instance
    logic          cpu_req, cpu_we, dev_req, dev_we, dev_lock;
    logic [AW-1:0] cpu_addr, dev_addr;
    logic [DW-1:0] cpu_wdata, dev_wdata;
    logic          cpu_ack, cpu_err, dev_ack, dev_err, mem_en, mem_we, busy;
    logic [DW-1:0] cpu_rdata, dev_rdata, mem_wdata, mem_rdata;
    logic [AW-3:0] mem_addr;

    // MEM_LAT=3 instance
    logic          cpu_req3, dev_req3;
    logic [AW-1:0] cpu_addr3;
    logic          cpu_ack3, cpu_err3, dev_ack3, dev_err3, mem_en3, mem_we3, busy3;
    logic [DW-1:0] cpu_rdata3, dev_rdata3, mem_wdata3, mem_rdata3;
    logic [AW-3:0] mem_addr3;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(1), .MEM_WORDS(256)) u_dut1 (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_err(cpu_err), .cpu_rdata(cpu_rdata),
        .dev_req(dev_req), .dev_we(dev_we), .dev_addr(dev_addr), .dev_wdata(dev_wdata),
        .dev_lock(dev_lock), .dev_ack(dev_ack), .dev_err(dev_err), .dev_rdata(dev_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(3), .MEM_WORDS(256)) u_dut3 (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req3), .cpu_we(1'b0), .cpu_addr(cpu_addr3), .cpu_wdata(32'h0),
        .cpu_ack(cpu_ack3), .cpu_err(cpu_err3), .cpu_rdata(cpu_rdata3),
        .dev_req(dev_req3), .dev_we(1'b0), .dev_addr(32'h400), .dev_wdata(32'h0),
        .dev_lock(1'b0), .dev_ack(dev_ack3), .dev_err(dev_err3), .dev_rdata(dev_rdata3),
        .mem_en(mem_en3), .mem_we(mem_we3), .mem_addr(mem_addr3), .mem_wdata(mem_wdata3),
        .mem_rdata(mem_rdata3), .busy(busy3)
    );

    function automatic logic [31:0] init1(input int i);
        return (i == 4) ? 32'hDEADBEEF : (32'hA500_0000 | 32'(i));
    endfunction

    function automatic logic [31:0] init3(input int i);
        return (i == 4) ? 32'h33334444 : (32'h3000_0000 | 32'(i));
    endfunction

    // Memory models drive a poison value except in the exact valid cycle.
    logic [DW-1:0] mem1 [256];
    logic          wr1  [256];
    logic          v1;
    logic [DW-1:0] d1;
    always @(posedge clk) begin
        v1 <= mem_en & ~mem_we;
        d1 <= wr1[mem_addr[7:0]] ? mem1[mem_addr[7:0]] : init1(int'(mem_addr[7:0]));
        if (!reset) begin
            for (int i = 0; i < 256; i++) wr1[i] <= 1'b0;
        end else if (mem_en && mem_we) begin
            mem1[mem_addr[7:0]] <= mem_wdata;
            wr1[mem_addr[7:0]]  <= 1'b1;
        end
    end
    assign mem_rdata = v1 ? d1 : 32'hBAD0BAD0;

    logic [2:0]    v3;
    logic [DW-1:0] d3 [3];
    always @(posedge clk) begin
        v3    <= {v3[1:0], mem_en3 & ~mem_we3};
        d3[0] <= init3(int'(mem_addr3[7:0]));
        d3[1] <= d3[0];
        d3[2] <= d3[1];
    end
    assign mem_rdata3 = v3[2] ? d3[2] : 32'hBAD0BAD0;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        dev;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          exp_lat;
        logic        exp_err;
        logic [31:0] exp_rdata;
        int          exp_en;
        logic [29:0] exp_en_addr;
    } vec_t;

    vec_t vecs [10];

    task automatic run_txn(input vec_t v, output int lat, output logic err,
                           output logic [31:0] rdata, output int en_cnt,
                           output logic [29:0] en_addr, output logic en_we,
                           output logic other_ack, output logic ack_after);
        @(negedge clk);
        if (v.dev) begin
            dev_req = 1'b1; dev_we = v.we; dev_addr = v.addr; dev_wdata = v.wdata;
        end else begin
            cpu_req = 1'b1; cpu_we = v.we; cpu_addr = v.addr; cpu_wdata = v.wdata;
        end
        lat = 0; err = 1'b0; rdata = '0; en_cnt = 0; en_addr = '0; en_we = 1'b0;
        other_ack = 1'b0; ack_after = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (mem_en) begin en_cnt++; en_addr = mem_addr; en_we = mem_we; end
            if (v.dev ? cpu_ack : dev_ack) other_ack = 1'b1;
            if (v.dev ? dev_ack : cpu_ack) begin
                lat   = c;
                err   = v.dev ? dev_err : cpu_err;
                rdata = v.dev ? dev_rdata : cpu_rdata;
                break;
            end
        end
        cpu_req = 1'b0;
        dev_req = 1'b0;
        @(negedge clk);
        ack_after = cpu_ack | dev_ack;
    endtask

    int          lat, en_cnt, n, en_c;
    logic        err, en_we, other_ack, ack_after, other3, seen;
    logic [31:0] rdata;
    logic [29:0] en_addr;
    logic        seq [4];
    int          at  [4];

    initial begin
        //        dev   we    addr           wdata          lat err rdata          en addr
        vecs[0] = '{1'b0, 1'b0, 32'h0000_0010, 32'h0,        3, 1'b0, 32'hDEADBEEF, 1, 30'd4};
        vecs[1] = '{1'b1, 1'b1, 32'h0000_0020, 32'h12345678, 2, 1'b0, 32'h0,        1, 30'd8};
        vecs[2] = '{1'b1, 1'b0, 32'h0000_0020, 32'h0,        3, 1'b0, 32'h12345678, 1, 30'd8};
        vecs[3] = '{1'b0, 1'b1, 32'h0000_0400, 32'h55AA55AA, 1, 1'b1, 32'h0,        0, 30'd0};
        vecs[4] = '{1'b0, 1'b0, 32'h0000_03FC, 32'h0,        3, 1'b0, 32'hA50000FF, 1, 30'd255};
        vecs[5] = '{1'b1, 1'b0, 32'h0000_0400, 32'h0,        1, 1'b1, 32'h0,        0, 30'd0};
        vecs[6] = '{1'b0, 1'b0, 32'hFFFF_FFFC, 32'h0,        1, 1'b1, 32'h0,        0, 30'd0};
        vecs[7] = '{1'b0, 1'b1, 32'h0000_0000, 32'hCAFEF00D, 2, 1'b0, 32'h0,        1, 30'd0};
        vecs[8] = '{1'b0, 1'b0, 32'h0000_0000, 32'h0,        3, 1'b0, 32'hCAFEF00D, 1, 30'd0};
        vecs[9] = '{1'b1, 1'b0, 32'h0000_0013, 32'h0,        3, 1'b0, 32'hDEADBEEF, 1, 30'd4};

        cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
        dev_req = 0; dev_we = 0; dev_addr = 0; dev_wdata = 0; dev_lock = 0;
        cpu_req3 = 0; dev_req3 = 0; cpu_addr3 = 0;

        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_mem_en", mem_en, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_acks", {cpu_ack, dev_ack, cpu_err, dev_err}, 0);
        chk("rst_rdata", {cpu_rdata, dev_rdata}, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_busy3", busy3, 0);
        reset = 1'b1;

        for (int i = 0; i < 10; i++) begin
            run_txn(vecs[i], lat, err, rdata, en_cnt, en_addr, en_we, other_ack, ack_after);
            chk($sformatf("v%0d_lat", i), lat, vecs[i].exp_lat);
            chk($sformatf("v%0d_err", i), err, vecs[i].exp_err);
            chk($sformatf("v%0d_mem_en_cnt", i), en_cnt, vecs[i].exp_en);
            chk($sformatf("v%0d_other_ack", i), other_ack, 0);
            chk($sformatf("v%0d_ack_width", i), ack_after, 0);
            if (!vecs[i].we) chk($sformatf("v%0d_rdata", i), rdata, vecs[i].exp_rdata);
            if (vecs[i].exp_en != 0) begin
                chk($sformatf("v%0d_mem_addr", i), en_addr, vecs[i].exp_en_addr);
                chk($sformatf("v%0d_mem_we", i), en_we, vecs[i].we);
            end
        end
        chk("cpu_rdata_hold", cpu_rdata, 32'hCAFEF00D);

        // Tie from reset: device first, then strict alternation.
        @(negedge clk);
        reset = 1'b0;
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'h10;
        dev_req = 1; dev_we = 0; dev_addr = 32'h20;
        @(negedge clk);
        reset = 1'b1;
        n = 0;
        for (int i = 0; i < 4; i++) begin seq[i] = 1'b0; at[i] = 0; end
        for (int c = 1; c <= 40 && n < 4; c++) begin
            @(negedge clk);
            if (cpu_ack && dev_ack) chk("tie_dual_ack", 1, 0);
            if (cpu_ack || dev_ack) begin
                seq[n] = dev_ack; at[n] = c; n++;
                if (n == 4) begin cpu_req = 0; dev_req = 0; end
            end
        end
        cpu_req = 0; dev_req = 0;
        chk("tie_count", n, 4);
        chk("tie_first_lat", at[0], 3);
        for (int i = 0; i < 4; i++) chk($sformatf("tie_owner%0d", i), seq[i], (i % 2 == 0));
        for (int i = 1; i < 4; i++) chk($sformatf("tie_gap%0d", i), at[i] - at[i-1], 4);
        repeat (2) @(negedge clk);

        // Device lock: three device writes back to back, then the CPU.
        dev_lock = 1; dev_req = 1; dev_we = 1; dev_addr = 32'h40; dev_wdata = 32'h11110000;
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'h10;
        n = 0;
        for (int i = 0; i < 4; i++) begin seq[i] = 1'b0; at[i] = 0; end
        for (int c = 1; c <= 60 && n < 4; c++) begin
            @(negedge clk);
            if (cpu_ack || dev_ack) begin
                seq[n] = dev_ack; at[n] = c; n++;
                if (n == 3) dev_lock = 0;
                if (n == 4) begin cpu_req = 0; dev_req = 0; end
            end
        end
        cpu_req = 0; dev_req = 0; dev_lock = 0;
        chk("lock_count", n, 4);
        chk("lock_owner0", seq[0], 1);
        chk("lock_owner1", seq[1], 1);
        chk("lock_owner2", seq[2], 1);
        chk("lock_owner3", seq[3], 0);
        chk("lock_wr_gap", at[2] - at[1], 3);
        repeat (2) @(negedge clk);

        // MEM_LAT=3 read with device request toggling during the access.
        @(negedge clk);
        cpu_req3 = 1; cpu_addr3 = 32'h10;
        lat = 0; en_cnt = 0; en_c = 0; other3 = 0; rdata = '0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (mem_en3) begin en_cnt++; en_c = c; end
            if (dev_ack3) other3 = 1;
            if (cpu_ack3) begin lat = c; rdata = cpu_rdata3; break; end
            dev_req3 = (c < 4) && (c % 2 == 1);
        end
        cpu_req3 = 0; dev_req3 = 0;
        chk("lat3_ack_cycle", lat, 5);
        chk("lat3_rdata", rdata, 32'h33334444);
        chk("lat3_mem_en_cnt", en_cnt, 1);
        chk("lat3_mem_en_cycle", en_c, 1);
        seen = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (dev_ack3 || cpu_ack3) seen = 1;
        end
        chk("lat3_dev_ignored", other3 | seen, 0);
        chk("lat3_idle", busy3, 0);

        // Reset during WAIT aborts without ack or replay.
        @(negedge clk);
        cpu_req3 = 1; cpu_addr3 = 32'h14;
        @(negedge clk);
        chk("abort_issue_en", mem_en3, 1);
        @(negedge clk);
        chk("abort_wait_busy", busy3, 1);
        #2 reset = 1'b0;
        #1;
        chk("abort_busy", busy3, 0);
        chk("abort_mem_en", mem_en3, 0);
        chk("abort_ack", cpu_ack3, 0);
        cpu_req3 = 0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        seen = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (cpu_ack3 || busy3 || mem_en3) seen = 1;
        end
        chk("abort_no_replay", seen, 0);
        chk("abort_rdata", cpu_rdata3, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end
endmodule
